// File: rtl/eg_arb_pkg.sv
// Shared types and constants for the eg sequencing arbiter.
// Holds the FSM state encoding and the widths of vector, ID and result.
package eg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    RESP,
    GAP
  } state_e;

  localparam int VEC_W = 3;
  localparam int ID_W  = 1;
  localparam int GF_W  = 2;

  localparam logic [VEC_W-1:0] X_IDLE = 3'b000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that did not win last time is granted.
module rr_arb2
  import eg_arb_pkg::*;
(
  input  logic            valid0,
  input  logic            valid1,
  input  logic [ID_W-1:0] last_id,
  output logic            grant0,
  output logic            grant1,
  output logic [ID_W-1:0] grant_id
);

  // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    grant0   = valid0 && (!valid1 || (last_id == 1'b1));
    grant1   = valid1 && (!valid0 || (last_id == 1'b0));
    grant_id = grant1 ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/eg_arbiter.sv
// Shares one eg circuit between two requesters: grant, drive x for a settle
// window, sample {g,f}, return the tagged result over a valid/ready handshake.
module eg_arbiter
  import eg_arb_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int GAP_CYC    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [VEC_W-1:0] req0_vec,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [VEC_W-1:0] req1_vec,
  output logic             req1_ready,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  input  logic             g,
  input  logic             f,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [GF_W-1:0]  rsp_gf,
  input  logic             rsp_ready
);

  localparam int CNT_W = $clog2(max2(SETTLE_CYC, GAP_CYC) + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [GF_W-1:0]    rsp_gf_q, rsp_gf_d;

  logic               grant0, grant1;
  logic [ID_W-1:0]    grant_id;
  logic               req_fire;

  rr_arb2 u_arb (
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .last_id  (last_id_q),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= X_IDLE;
      id_q        <= '0;
      last_id_q   <= ID_W'(1);
      rsp_valid_q <= 1'b0;
      rsp_gf_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_gf_q    <= rsp_gf_d;
    end
  end

  assign req_fire = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_gf_d    = rsp_gf_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          vec_d     = grant1 ? req1_vec : req0_vec;
          id_d      = grant_id;
          last_id_d = grant_id;
          cnt_d     = CNT_W'(SETTLE_CYC);
          state_d   = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_gf_d    = {g, f};
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (GAP_CYC > 0) begin
            cnt_d   = CNT_W'(GAP_CYC);
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready looks only at state, reset and the request valids, never at rsp_ready.
  always_comb begin
    {x1, x2, x3} = (state_q == APPLY) ? vec_q : X_IDLE;
    req0_ready   = (state_q == IDLE) && !rst && grant0;
    req1_ready   = (state_q == IDLE) && !rst && grant1;
    rsp_valid    = rsp_valid_q;
    rsp_id       = id_q;
    rsp_gf       = rsp_gf_q;
  end

endmodule

// File: tb/tb_eg_arbiter.sv
// Directed bench for eg_arbiter with a small registered eg model attached:
// table-driven transactions plus hand-written reset/contention/backpressure/gap sequences.
module tb_eg_arbiter;
  import eg_arb_pkg::*;

  localparam int SETTLE = 2;
  localparam int GAPC   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_vec = 3'b000, req1_vec = 3'b000;
  logic       req0_ready, req1_ready;
  logic       x1, x2, x3;
  logic       g = 1'b0, f = 1'b0;
  logic       rsp_valid;
  logic       rsp_id;
  logic [1:0] rsp_gf;
  logic       rsp_ready = 1'b0;
  logic [2:0] xv;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  eg_arbiter #(.SETTLE_CYC(SETTLE), .GAP_CYC(GAPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_vec   (req0_vec),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_vec   (req1_vec),
    .req1_ready (req1_ready),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .g          (g),
    .f          (f),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_gf     (rsp_gf),
    .rsp_ready  (rsp_ready)
  );

  assign xv = {x1, x2, x3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // eg stand-in: registered g = parity of x, f = (x1 & x2) | x3.
  always @(posedge clk) begin
    g <= x1 ^ x2 ^ x3;
    f <= (x1 & x2) | x3;
  end

  function automatic logic [1:0] eg_gf(input logic [2:0] v);
    return {^v, (v[2] & v[1]) | v[0]};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic wait_hs(input string name, output logic id, output int hs_cyc);
    bit got = 1'b0;
    id = 1'b0;
    hs_cyc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) next_cycle();
      mid();
      if (req0_valid && req0_ready) begin
        got = 1'b1; id = 1'b0; hs_cyc = cyc;
      end else if (req1_valid && req1_ready) begin
        got = 1'b1; id = 1'b1; hs_cyc = cyc;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: no handshake within 20 cycles", name);
    end
  endtask

  task automatic wait_rsp(input string name, input logic exp_id, input logic [1:0] exp_gf,
                          input int hs_cyc, output int r_cyc);
    bit got = 1'b0;
    r_cyc = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      if (i > 0) next_cycle();
      mid();
      if (rsp_valid) begin
        got = 1'b1;
        check({name, "_lat"}, 8'(cyc - hs_cyc), 8'(SETTLE + 1));
        check({name, "_id"}, rsp_id, exp_id);
        check({name, "_gf"}, rsp_gf, exp_gf);
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: no response within 12 cycles", name);
    end
    rsp_ready = 1'b1;
    r_cyc = cyc;
    next_cycle();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic       v0;
    logic [2:0] vec0;
    logic       v1;
    logic [2:0] vec1;
    logic       exp_id;
    logic [1:0] exp_gf;
  } vec_t;

  localparam int NV = 7;
  vec_t tv[NV];

  initial begin
    logic id;
    int   hs, r, n;
    logic ids[4];
    int   hcyc[4];
    logic exp_ids[4];

    // Arbitration outcomes follow last_id, which is 0 after the single-request test.
    tv[0] = '{1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 2'b01};
    tv[1] = '{1'b0, 3'b000, 1'b1, 3'b110, 1'b1, 2'b01};
    tv[2] = '{1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 2'b11};
    tv[3] = '{1'b1, 3'b100, 1'b1, 3'b010, 1'b1, 2'b10};
    tv[4] = '{1'b0, 3'b000, 1'b1, 3'b001, 1'b1, 2'b11};
    tv[5] = '{1'b1, 3'b000, 1'b1, 3'b101, 1'b0, 2'b00};
    tv[6] = '{1'b1, 3'b110, 1'b1, 3'b100, 1'b1, 2'b10};

    // Reset held with a pending request.
    req0_valid = 1'b1;
    req0_vec   = 3'b101;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mid();
      check("rst_ready0", req0_ready, 1'b0);
      check("rst_x", xv, 3'b000);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_gf", rsp_gf, 2'b00);
      check("rst_rsp_id", rsp_id, 1'b0);
    end

    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b0;
    mid();
    check("idle_no_valid_ready0", req0_ready, 1'b0);

    // Single request, cycle by cycle.
    next_cycle();
    req0_valid = 1'b1;
    req0_vec   = 3'b101;
    mid();
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    next_cycle();
    req0_valid = 1'b0;
    mid();
    check("single_x_c1", xv, 3'b101);
    check("single_rv_c1", rsp_valid, 1'b0);
    next_cycle();
    mid();
    check("single_x_c2", xv, 3'b101);
    check("single_rv_c2", rsp_valid, 1'b0);
    next_cycle();
    mid();
    check("single_rv_c3", rsp_valid, 1'b1);
    check("single_id", rsp_id, 1'b0);
    check("single_gf", rsp_gf, eg_gf(3'b101));
    check("single_x_resp", xv, 3'b000);
    rsp_ready = 1'b1;
    next_cycle();
    rsp_ready = 1'b0;
    mid();
    check("single_rv_clear", rsp_valid, 1'b0);
    next_cycle();

    // Table-driven transactions.
    for (int i = 0; i < NV; i++) begin
      req0_valid = tv[i].v0;
      req0_vec   = tv[i].vec0;
      req1_valid = tv[i].v1;
      req1_vec   = tv[i].vec1;
      wait_hs($sformatf("tv%0d_hs", i), id, hs);
      check($sformatf("tv%0d_grant", i), id, tv[i].exp_id);
      check($sformatf("tv%0d_onehot", i), req0_ready & req1_ready, 1'b0);
      next_cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp($sformatf("tv%0d", i), tv[i].exp_id, tv[i].exp_gf, hs, r);
    end

    // Contention: both valid continuously, consumer always ready.
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
    req0_valid = 1'b1; req0_vec = 3'b001;
    req1_valid = 1'b1; req1_vec = 3'b110;
    rsp_ready  = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (i > 0) next_cycle();
      mid();
      if (req0_valid && req0_ready) begin
        ids[n] = 1'b0; hcyc[n] = cyc; n++;
      end else if (req1_valid && req1_ready) begin
        ids[n] = 1'b1; hcyc[n] = cyc; n++;
      end
    end
    check("cont_count", 8'(n), 8'd4);
    for (int k = 0; k < n; k++) check($sformatf("cont_id%0d", k), ids[k], exp_ids[k]);
    for (int k = 1; k < n; k++)
      check($sformatf("cont_gap%0d", k), 8'(hcyc[k] - hcyc[k-1]), 8'(SETTLE + GAPC + 2));
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) next_cycle();
    rsp_ready = 1'b0;

    // Backpressure: response held for 6 cycles while both requesters wait.
    req1_valid = 1'b1; req1_vec = 3'b011;
    wait_hs("bp_hs", id, hs);
    check("bp_grant", id, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    next_cycle();
    req0_valid = 1'b1; req0_vec = 3'b010;
    req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      mid();
      check($sformatf("bp_rv%0d", k), rsp_valid, 1'b1);
      check($sformatf("bp_id%0d", k), rsp_id, 1'b1);
      check($sformatf("bp_gf%0d", k), rsp_gf, eg_gf(3'b011));
      check($sformatf("bp_ready%0d", k), {req0_ready, req1_ready}, 2'b00);
      check($sformatf("bp_x%0d", k), xv, 3'b000);
    end
    next_cycle();
    mid();
    check("bp_rv_accept", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    r = cyc;
    next_cycle();
    rsp_ready = 1'b0;
    mid();
    check("bp_rv_after", rsp_valid, 1'b0);
    check("bp_gap_ready", {req0_ready, req1_ready}, 2'b00);
    check("bp_gap_x", xv, 3'b000);
    next_cycle();
    mid();
    check("bp_next_ready", {req0_ready, req1_ready}, 2'b10);
    check("bp_next_delay", 8'(cyc - r), 8'd2);
    hs = cyc;
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("bp_follow", 1'b0, eg_gf(3'b010), hs, r);

    // Gap: req1 held valid across its own response accept.
    req1_valid = 1'b1; req1_vec = 3'b101;
    wait_hs("gap_hs", id, hs);
    check("gap_grant", id, 1'b1);
    next_cycle();
    wait_rsp("gap_rsp", 1'b1, eg_gf(3'b101), hs, r);
    mid();
    check("gap_x", xv, 3'b000);
    check("gap_ready1_r1", req1_ready, 1'b0);
    check("gap_rv_r1", rsp_valid, 1'b0);
    next_cycle();
    mid();
    check("gap_ready1_r2", req1_ready, 1'b1);
    check("gap_delay", 8'(cyc - r), 8'd2);
    hs = cyc;
    next_cycle();
    req1_valid = 1'b0;
    wait_rsp("gap_follow", 1'b1, eg_gf(3'b101), hs, r);

    // Reset during APPLY discards the result.
    req1_valid = 1'b1; req1_vec = 3'b011;
    wait_hs("rst_apply_hs", id, hs);
    check("rst_apply_grant", id, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    rst = 1'b1;
    mid();
    check("rst_apply_x_t1", xv, 3'b011);
    check("rst_apply_ready_t1", {req0_ready, req1_ready}, 2'b00);
    next_cycle();
    req0_valid = 1'b1; req0_vec = 3'b100;
    req1_valid = 1'b1;
    mid();
    check("rst_apply_x_t2", xv, 3'b000);
    check("rst_apply_rv_t2", rsp_valid, 1'b0);
    check("rst_apply_ready_t2", {req0_ready, req1_ready}, 2'b00);
    next_cycle();
    rst = 1'b0;
    mid();
    check("rst_release_ready", {req0_ready, req1_ready}, 2'b10);
    check("rst_release_rv", rsp_valid, 1'b0);
    hs = cyc;
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("rst_follow", 1'b0, eg_gf(3'b100), hs, r);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
